// File: rtl/pjdl_medium_access.sv
`timescale 1ns/1ps
// pjdl_medium_access: medium-access controller and TX arbiter in front of pjdl_send.
// Requester 0 (ACK path) has strict priority and skips carrier sense; the others
// are served round-robin after idle_time_i idle cycles plus an LFSR-driven backoff.
// Optional statistics outputs are enabled by defining PJDL_MAC_STATS_EN.
module pjdl_medium_access #(
    parameter int          NumReq      = 2,
    parameter int          BackoffBits = 4,
    parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [NumReq-1:0]     req_valid_i,
    input  logic [NumReq*8-1:0]   req_data_i,
    input  logic [NumReq-1:0]     req_last_i,
    input  logic [NumReq*2-1:0]   req_user_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_last_o,
    output logic [1:0]            tx_user_o,
    input  logic                  tx_ready_i,
    input  logic                  bus_busy_i,
    input  logic                  send_busy_i,
    input  logic [19:0]           idle_time_i,
    input  logic [15:0]           backoff_unit_i,
`ifdef PJDL_MAC_STATS_EN
    output logic [15:0]           defer_cnt_o,
    output logic [15:0]           frame_cnt_o,
`endif
    output logic [NumReq-1:0]     grant_o
);

    localparam int IW = $clog2(NumReq);
    localparam int BW = BackoffBits + 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SENSE,
        ST_BACKOFF,
        ST_GRANT,
        ST_GUARD
    } state_t;

    state_t             r_state;
    logic [IW-1:0]      r_winner;
    logic [IW-1:0]      r_rr_ptr;
    logic [NumReq-1:0]  r_grant;
    logic [15:0]        r_lfsr;
    logic [19:0]        r_idle_cnt;
    logic [BW-1:0]      r_bo_cnt;
    logic [19:0]        r_guard_cnt;
    logic               r_seen_busy;
`ifdef PJDL_MAC_STATS_EN
    logic [15:0]        r_defer_cnt;
    logic [15:0]        r_frame_cnt;
`endif

    logic [IW-1:0]      w_rr_idx;
    logic [IW-1:0]      w_cand;
    logic [20:0]        w_idle_inc;
    logic [BW-1:0]      w_bo_load;
    logic               w_tx_done;

    function automatic logic [NumReq-1:0] f_onehot(input logic [IW-1:0] idx);
        logic [NumReq-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Pointer advances past the owner just served; the ACK path never moves it.
    function automatic logic [IW-1:0] f_next_ptr(input logic [IW-1:0] w, input logic [IW-1:0] p);
        if (w == '0)                 return p;
        else if (w == IW'(NumReq-1)) return IW'(1);
        else                         return w + IW'(1);
    endfunction

    assign w_idle_inc = {1'b0, r_idle_cnt} + 21'd1;
    assign w_bo_load  = BW'(r_lfsr[BackoffBits-1:0]) * BW'(backoff_unit_i);
    assign w_tx_done  = tx_valid_o & tx_ready_i & tx_last_o;

    // Round-robin search over requesters 1..NumReq-1 starting at r_rr_ptr.
    always_comb begin
        w_rr_idx = '0;
        w_cand   = '0;
        for (int off = NumReq - 2; off >= 0; off--) begin
            w_cand = IW'((int'(r_rr_ptr) - 1 + off) % (NumReq - 1) + 1);
            if (req_valid_i[w_cand]) w_rr_idx = w_cand;
        end
    end

    // Zero-latency passthrough of the granted requester to the sender.
    always_comb begin
        tx_valid_o = 1'b0;
        tx_data_o  = '0;
        tx_last_o  = 1'b0;
        tx_user_o  = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (r_grant[i]) begin
                tx_valid_o = req_valid_i[i];
                tx_data_o  = req_data_i[i*8 +: 8];
                tx_last_o  = req_last_i[i];
                tx_user_o  = req_user_i[i*2 +: 2];
            end
        end
    end

    assign req_ready_o = r_grant & {NumReq{tx_ready_i}};
    assign grant_o     = r_grant;
`ifdef PJDL_MAC_STATS_EN
    assign defer_cnt_o = r_defer_cnt;
    assign frame_cnt_o = r_frame_cnt;
`endif

    // Free-running Fibonacci LFSR (taps 16,14,13,11), shifting toward bit 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_lfsr <= LfsrSeed;
        else       r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end

    // Arbitration / carrier-sense / backoff / grant / guard state machine.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_winner    <= '0;
            r_rr_ptr    <= IW'(1);
            r_grant     <= '0;
            r_idle_cnt  <= '0;
            r_bo_cnt    <= '0;
            r_guard_cnt <= '0;
            r_seen_busy <= 1'b0;
`ifdef PJDL_MAC_STATS_EN
            r_defer_cnt <= '0;
            r_frame_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_grant <= '0;
                    if (enable_i && (|req_valid_i)) begin
                        if (req_valid_i[0]) begin
                            // ACK must follow the received frame: no sense, no backoff.
                            r_winner <= '0;
                            r_grant  <= f_onehot('0);
                            r_state  <= ST_GRANT;
                        end else begin
                            r_winner   <= w_rr_idx;
                            r_idle_cnt <= '0;
                            r_state    <= ST_SENSE;
                        end
                    end
                end
                ST_SENSE: begin
                    if (!enable_i) begin
                        r_idle_cnt <= '0;
                        r_state    <= ST_IDLE;
                    end else if (req_valid_i[0]) begin
                        r_winner <= '0;
                        r_grant  <= f_onehot('0);
                        r_state  <= ST_GRANT;
                    end else if (bus_busy_i) begin
                        r_idle_cnt <= '0;
                    end else if (w_idle_inc >= {1'b0, idle_time_i}) begin
                        r_idle_cnt <= '0;
                        r_bo_cnt   <= w_bo_load;
                        r_state    <= ST_BACKOFF;
                    end else begin
                        r_idle_cnt <= w_idle_inc[19:0];
                    end
                end
                ST_BACKOFF: begin
                    if (!enable_i) begin
                        r_bo_cnt <= '0;
                        r_state  <= ST_IDLE;
                    end else if (req_valid_i[0]) begin
                        r_winner <= '0;
                        r_grant  <= f_onehot('0);
                        r_state  <= ST_GRANT;
                    end else if (bus_busy_i) begin
                        r_idle_cnt <= '0;
                        r_bo_cnt   <= '0;
                        r_state    <= ST_SENSE;
`ifdef PJDL_MAC_STATS_EN
                        if (r_defer_cnt != 16'hFFFF) r_defer_cnt <= r_defer_cnt + 16'd1;
`endif
                    end else if (r_bo_cnt == '0) begin
                        r_grant <= f_onehot(r_winner);
                        r_state <= ST_GRANT;
                    end else begin
                        r_bo_cnt <= r_bo_cnt - BW'(1);
                    end
                end
                ST_GRANT: begin
                    // enable_i is deliberately ignored here so a frame always completes.
                    if (w_tx_done) begin
                        r_grant     <= '0;
                        r_seen_busy <= 1'b0;
                        r_guard_cnt <= '0;
                        r_state     <= ST_GUARD;
`ifdef PJDL_MAC_STATS_EN
                        if (r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
`endif
                    end
                end
                ST_GUARD: begin
                    if (send_busy_i) r_seen_busy <= 1'b1;
                    if (r_seen_busy && !send_busy_i) begin
                        r_rr_ptr <= f_next_ptr(r_winner, r_rr_ptr);
                        r_state  <= ST_IDLE;
                    end else if (!r_seen_busy && (r_guard_cnt == 20'hFFFFF)) begin
                        // Sender never reported busy: give up rather than lock the medium.
                        r_rr_ptr <= f_next_ptr(r_winner, r_rr_ptr);
                        r_state  <= ST_IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + 20'd1;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
